status_frame_tx: RTL

STATUS_FRAME_TX -- requirements
Module: status_frame_tx

---
 rtl/status_frame_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/status_frame_tx.sv
// Status frame transmitter: snapshots board status into an 8-byte frame and
// feeds it to a UART transmit FIFO one byte at a time, with optional heartbeat.
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module status_frame_tx #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HB_PERIOD  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            send_req,
  input  logic [7:0]                      cmd_code,
  input  logic                            switch,
  input  logic                            power_on_A,
  input  logic                            power_on_B,
  input  logic                            reset_a_signal,
  input  logic                            reset_b_signal,
  input  logic                            error,
  input  logic [`UART_FIFO_COUNTER_W-1:0] tf_count,
  output logic                            tf_push,
  output logic [7:0]                      tdr,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int unsigned CW = `UART_FIFO_COUNTER_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SPACE, PUSH, GAP, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic       gap_cnt;
  logic       pending, pend_hb, hb_frame;
  logic [7:0] cmd_q, stat_q, chk, byte_nx;
  logic       tick, req, space;

  assign space = (tf_count < DEPTH_C);
  assign req   = send_req | tick | pending;
  assign chk   = 8'h00 - cmd_q - 8'hAB - stat_q;

  // Free-running heartbeat counter; one tick every HB_PERIOD cycles.
  if (HB_PERIOD > 0) begin : g_hb
    localparam int unsigned HW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    logic [HW-1:0] hb_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        hb_cnt <= '0;
      end else if (hb_cnt == HW'(HB_PERIOD - 1)) begin
        hb_cnt <= '0;
      end else begin
        hb_cnt <= hb_cnt + HW'(1);
      end
    end
    assign tick = (hb_cnt == HW'(HB_PERIOD - 1));
  end else begin : g_no_hb
    assign tick = 1'b0;
  end

  // Next state; the space check is folded into LOAD/GAP exits so pushes are 3 cycles apart.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE:       if (req) state_nx = LOAD;
      LOAD: begin
        idx_nx   = 3'd0;
        state_nx = space ? PUSH : WAIT_SPACE;
      end
      WAIT_SPACE: if (space) state_nx = PUSH;
      PUSH:       state_nx = GAP;
      GAP: begin
        if (gap_cnt) begin
          if (idx == 3'd7) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = space ? PUSH : WAIT_SPACE;
          end
        end
      end
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_nx = 8'hEB;
    case (idx_nx)
      3'd0: byte_nx = 8'hEB;
      3'd1: byte_nx = 8'h90;
      3'd2: byte_nx = cmd_q;
      3'd3: byte_nx = 8'hAB;
      3'd4: byte_nx = stat_q;
      3'd5: byte_nx = chk;
      3'd6: byte_nx = 8'h09;
      3'd7: byte_nx = 8'hD7;
      default: byte_nx = 8'hEB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      gap_cnt    <= 1'b0;
      pending    <= 1'b0;
      pend_hb    <= 1'b0;
      hb_frame   <= 1'b0;
      cmd_q      <= 8'h00;
      stat_q     <= 8'h00;
      tf_push    <= 1'b0;
      tdr        <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      gap_cnt    <= (state == GAP) && !gap_cnt;
      tf_push    <= (state_nx == PUSH);
      busy       <= (state_nx != IDLE);
      frame_done <= (state_nx == DONE);
      if (state_nx == PUSH) tdr <= byte_nx;

      // One pending slot; a request seen while busy is remembered, later ones dropped.
      if (state == IDLE && req) begin
        pending  <= 1'b0;
        hb_frame <= pending ? pend_hb : (tick & ~send_req);
      end else if (state != IDLE && (send_req | tick) && !pending) begin
        pending <= 1'b1;
        pend_hb <= ~send_req;
      end

      if (state == LOAD) begin
        cmd_q  <= hb_frame ? 8'h00 : cmd_code;
        stat_q <= {2'b00, error, reset_b_signal, reset_a_signal,
                   power_on_B, power_on_A, switch};
      end
    end
  end

endmodule
